sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Two-master arbiter that shares one sram-like memory port between the instruction-fetch interface and the data-memory interface of the pipelined MIPS core. It sits between the core's fetch/MEM stages and the external bus bridge. Only one transaction is outstanding at any time. Requests follow a two-phase handshake:

- address phase: `req`/`addr_ok`;
- data phase: `data_ok`.

The arbiter holds a grant from address acceptance until the matching data return.

## Interface

Parameters:

- `DATA_FIRST`, default 1, meaning: 1 = data side wins simultaneous requests in IDLE; 0 = inst side wins.

Ports:

- Reset: synchronous, active-high, sampled on `posedge clk`.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `inst_req`  in  1  fetch request; held until `inst_addr_ok`.
- `inst_addr`  in  32  fetch address.
- `inst_addr_ok`  out  1  fetch address accepted this cycle.
- `inst_data_ok`  out  1  fetch data valid this cycle.
- `inst_rdata`  out  32  fetch read data; equals `bus_rdata`.
- `data_req`  in  1  load/store request; held until `data_addr_ok`.
- `data_wr`  in  1  1 = store.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  32  load/store address.
- `data_wdata`  in  32  store data.
- `data_addr_ok`  out  1  data address accepted this cycle.
- `data_data_ok`  out  1  load data valid / store complete this cycle.
- `data_rdata`  out  32  load data; equals `bus_rdata`.
- `bus_req`  out  1  request to memory bridge.
- `bus_wr`  out  1  write enable to bridge.
- `bus_size`  out  2  access size to bridge.
- `bus_addr`  out  32  address to bridge.
- `bus_wdata`  out  32  write data to bridge.
- `bus_addr_ok`  in  1  bridge accepted address.
- `bus_data_ok`  in  1  bridge returns data / write ack.
- `bus_rdata`  in  32  bridge read data.

## Operation

States:

- **IDLE**: no grant held.
  - Grant select is combinational. Both requesting → winner per `DATA_FIRST`; otherwise the sole requester wins.
  - Winner's request is driven on the bus the same cycle.
  - `bus_addr_ok`=1 in the same cycle → go to WAIT_I or WAIT_D, and pulse the winner's `*_addr_ok`.
  - `bus_addr_ok`=0 → go to REQ_I or REQ_D.
  - No request → stay, `bus_req`=0.
- **REQ_I / REQ_D**: grant held regardless of the other requester.
  - `bus_req` = granted `*_req`; bus fields come from the granted side.
  - `bus_addr_ok` → go to WAIT_x and pulse granted `*_addr_ok`.
  - Granted `*_req` drops before acceptance (flush) → go to IDLE; `bus_req`=0 that cycle.
- **WAIT_I / WAIT_D**: `bus_req`=0; both `*_addr_ok`=0.
  - On `bus_data_ok` → pulse granted `*_data_ok` and go to IDLE.
  - Next request can be issued no earlier than the following cycle.

Bus field muxing:

- Inst grant: `bus_wr`=0, `bus_size`=2, `bus_addr`=`inst_addr`, `bus_wdata`=0.
- Data grant: `data_*` fields passed through.
- `inst_rdata` and `data_rdata` are wired to `bus_rdata` unconditionally; they are valid only with their `*_data_ok`.
- `*_addr_ok` and `*_data_ok` are combinational from state and bus inputs; they are never asserted to the non-granted side.

Boundary conditions:

- `bus_data_ok` in IDLE/REQ: ignored; no `*_data_ok` and no state change.
- `bus_addr_ok` while `bus_req`=0: ignored.
- New request arriving during WAIT_x: not accepted; the requester keeps holding it.
- Requester drop in WAIT_x: no effect; the transaction completes and `*_data_ok` is still pulsed. The core discards the result.
- Starvation: none beyond one transaction. The losing side wins the next IDLE only if the winner is not requesting again the same cycle. With `DATA_FIRST`=1, back-to-back data requests may delay fetch; this is accepted, since the MEM stage issues at most one data request per instruction.

## Timing

- Reset:
  - state=IDLE;
  - `bus_req`, `inst_addr_ok`, `inst_data_ok`, `data_addr_ok`, `data_data_ok` = 0 while `rst` is high and in the first cycle after, unless a request is present.
  - A transaction in flight at reset is abandoned; its late `bus_data_ok` arrives in IDLE and is ignored.
- Latency:
  - Request to `bus_req`: 0 cycles.
  - Minimum transaction: 2 cycles (`addr_ok` in cycle 0, `data_ok` in cycle 1).
  - Minimum issue interval between transactions: 2 cycles.
- All outputs settle combinationally within the cycle; the only registered state is the 3-bit FSM.

## Test plan

- Reset then idle: `rst`=1 for 2 cycles with `inst_req`=0 and `data_req`=0 → all `*_ok` and `bus_req` stay 0; state IDLE.
- Single fetch:
  - Stimulus: `inst_req`=1 with `inst_addr`=0xBFC00000; `bus_addr_ok` in the same cycle; `bus_data_ok` with `bus_rdata`=0x3C010000 two cycles later.
  - Required: `bus_addr`=0xBFC00000, `bus_wr`=0, `bus_size`=2, `inst_addr_ok` pulses 1 cycle, `inst_data_ok` and `inst_rdata`=0x3C010000 in the same cycle as `bus_data_ok`.
- Conflict, `DATA_FIRST`=1:
  - Stimulus: `inst_req` and `data_req` (store, `data_addr`=0x80001000, `data_wdata`=0x12345678, `data_size`=2) asserted together; bridge accepts each after 1 wait cycle.
  - Required: the store is issued first with `bus_wr`=1. The fetch is issued in the cycle after `data_data_ok`, with `inst_addr_ok` never asserted earlier.
- Grant hold:
  - Stimulus: `inst_req` granted with `bus_addr_ok`=0 for 3 cycles; `data_req` rises in the second of those cycles.
  - Required: `bus_addr` stays `inst_addr`, and `data_addr_ok`=0 throughout.
- Flush in REQ:
  - Stimulus: `data_req` drops while in REQ_D.
  - Required: `bus_req`=0 that cycle and state returns to IDLE. A subsequent `bus_data_ok` pulse in IDLE produces no `*_data_ok`.
- Reset mid-WAIT:
  - Stimulus: assert `rst` in WAIT_I, then pulse `bus_data_ok` 1 cycle after reset release.
  - Required: `inst_data_ok` stays 0 and state is IDLE.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master arbiter sharing one sram-like bus between instruction fetch and data access.
// One transaction outstanding; grant held from address acceptance until data return.
module sram_like_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   sel_data;
  logic   issue;

  always_comb begin
    sel_data = 1'b0;
    issue    = 1'b0;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        sel_data = data_req & (DATA_FIRST | ~inst_req);
        issue    = inst_req | data_req;
        if (issue) begin
          if (bus_addr_ok) state_d = sel_data ? WAIT_D : WAIT_I;
          else             state_d = sel_data ? REQ_D  : REQ_I;
        end
      end
      // A dropped request (pipeline flush) releases the grant before acceptance.
      REQ_I: begin
        issue = inst_req;
        if (!inst_req)        state_d = IDLE;
        else if (bus_addr_ok) state_d = WAIT_I;
      end
      REQ_D: begin
        sel_data = 1'b1;
        issue    = data_req;
        if (!data_req)        state_d = IDLE;
        else if (bus_addr_ok) state_d = WAIT_D;
      end
      WAIT_I: begin
        if (bus_data_ok) state_d = IDLE;
      end
      WAIT_D: begin
        sel_data = 1'b1;
        if (bus_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign bus_req   = issue;
  assign bus_wr    = sel_data & data_wr;
  assign bus_size  = sel_data ? data_size  : 2'd2;
  assign bus_addr  = sel_data ? data_addr  : inst_addr;
  assign bus_wdata = sel_data ? data_wdata : 32'd0;

  // issue is only ever set in IDLE/REQ, so addr_ok can never fire during WAIT.
  assign inst_addr_ok = issue & ~sel_data & bus_addr_ok;
  assign data_addr_ok = issue &  sel_data & bus_addr_ok;
  assign inst_data_ok = (state_q == WAIT_I) & bus_data_ok;
  assign data_data_ok = (state_q == WAIT_D) & bus_data_ok;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with DATA_FIRST=1; inputs change 1ns after
// the rising edge and combinational outputs are sampled 1ns later.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  sram_like_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // reset then idle
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_inst_ok", {30'd0, inst_addr_ok, inst_data_ok}, 0);
      chk("rst_data_ok", {30'd0, data_addr_ok, data_data_ok}, 0);
    end
    cyc(); rst = 1'b0; settle();
    chk("idle_bus_req", 32'(bus_req), 0);

    // single fetch, accepted immediately
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00000; bus_addr_ok = 1'b1; settle();
    chk("f_bus_req", 32'(bus_req), 1);
    chk("f_bus_addr", bus_addr, 32'hBFC00000);
    chk("f_bus_wr", 32'(bus_wr), 0);
    chk("f_bus_size", 32'(bus_size), 2);
    chk("f_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("f_data_addr_ok", 32'(data_addr_ok), 0);
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; settle();
    chk("f_wait_addr_ok", 32'(inst_addr_ok), 0);
    chk("f_wait_bus_req", 32'(bus_req), 0);
    chk("f_wait_data_ok", 32'(inst_data_ok), 0);
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h3C010000; settle();
    chk("f_inst_data_ok", 32'(inst_data_ok), 1);
    chk("f_inst_rdata", inst_rdata, 32'h3C010000);
    chk("f_data_data_ok", 32'(data_data_ok), 0);
    cyc(); settle();
    chk("idle_dok_ignored", {30'd0, inst_data_ok, data_data_ok}, 0);

    // conflict: store wins, fetch waits for it to complete
    cyc(); bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h80001000; data_wdata = 32'h12345678; settle();
    chk("c_bus_req", 32'(bus_req), 1);
    chk("c_bus_wr", 32'(bus_wr), 1);
    chk("c_bus_addr", bus_addr, 32'h80001000);
    chk("c_bus_wdata", bus_wdata, 32'h12345678);
    chk("c_addr_ok0", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    cyc(); bus_addr_ok = 1'b1; settle();
    chk("c_data_addr_ok", 32'(data_addr_ok), 1);
    chk("c_inst_addr_ok1", 32'(inst_addr_ok), 0);
    chk("c_bus_addr1", bus_addr, 32'h80001000);
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b0; settle();
    chk("c_wait_bus_req", 32'(bus_req), 0);
    chk("c_wait_ok", {30'd0, inst_addr_ok, data_data_ok}, 0);
    cyc(); bus_data_ok = 1'b1; bus_addr_ok = 1'b1; bus_rdata = 32'h0; settle();
    chk("c_data_data_ok", 32'(data_data_ok), 1);
    chk("c_wait_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("c_wait_inst_dok", 32'(inst_data_ok), 0);
    cyc(); bus_data_ok = 1'b0; bus_addr_ok = 1'b0; settle();
    chk("c_fetch_bus_req", 32'(bus_req), 1);
    chk("c_fetch_bus_addr", bus_addr, 32'hBFC00004);
    chk("c_fetch_bus_wr", 32'(bus_wr), 0);
    chk("c_fetch_wdata", bus_wdata, 32'h0);
    chk("c_fetch_addr_ok0", 32'(inst_addr_ok), 0);
    cyc(); bus_addr_ok = 1'b1; settle();
    chk("c_fetch_addr_ok", 32'(inst_addr_ok), 1);
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; settle();
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D; settle();
    chk("c_fetch_data_ok", 32'(inst_data_ok), 1);
    chk("c_fetch_rdata", inst_rdata, 32'hCAFEF00D);

    // grant hold: data request arrives while fetch waits in REQ_I
    cyc(); bus_data_ok = 1'b0; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h80002000;
    inst_req = 1'b1; inst_addr = 32'hBFC00010; settle();
    chk("g0_bus_addr", bus_addr, 32'hBFC00010);
    for (int i = 0; i < 2; i++) begin
      cyc(); data_req = 1'b1; settle();
      chk("g_bus_addr", bus_addr, 32'hBFC00010);
      chk("g_bus_size", 32'(bus_size), 2);
      chk("g_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    end
    cyc(); bus_addr_ok = 1'b1; settle();
    chk("g_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("g_data_addr_ok", 32'(data_addr_ok), 0);
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; settle();
    chk("g_inst_data_ok", 32'(inst_data_ok), 1);
    chk("g_wait_data_addr_ok", 32'(data_addr_ok), 0);
    cyc(); bus_data_ok = 1'b0; settle();
    chk("g_data_addr_ok2", 32'(data_addr_ok), 1);
    chk("g_bus_addr2", bus_addr, 32'h80002000);
    chk("g_bus_size2", 32'(bus_size), 1);
    // requester drops in WAIT_D, completion still reported
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; settle();
    chk("g_drop_data_ok", 32'(data_data_ok), 1);

    // flush in REQ_D
    cyc(); bus_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h80003000; settle();
    chk("fl_bus_req", 32'(bus_req), 1);
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b1; settle();
    chk("fl_bus_req0", 32'(bus_req), 0);
    chk("fl_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; settle();
    chk("fl_dok_ignored", {30'd0, inst_data_ok, data_data_ok}, 0);
    cyc(); bus_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC00020; bus_addr_ok = 1'b1; settle();
    chk("fl_idle_accept", 32'(inst_addr_ok), 1);

    // reset while in WAIT_I
    cyc(); inst_req = 1'b0; bus_addr_ok = 1'b0; rst = 1'b1; settle();
    chk("rw_bus_req", 32'(bus_req), 0);
    cyc(); rst = 1'b0; settle();
    chk("rw_after_rst", {30'd0, inst_addr_ok, inst_data_ok}, 0);
    cyc(); bus_data_ok = 1'b1; settle();
    chk("rw_late_dok", 32'(inst_data_ok), 0);
    cyc(); bus_data_ok = 1'b0; data_req = 1'b1; bus_addr_ok = 1'b1; settle();
    chk("rw_idle_accept", 32'(data_addr_ok), 1);
    cyc(); data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; settle();
    chk("rw_data_ok", 32'(data_data_ok), 1);
    cyc(); bus_data_ok = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
